// File: rtl/arbitrated_multiplexor_pkg.sv
// Shared constants for the arbitrated multiplexor slice.
//   ARB_ROUND_ROBIN / ARB_FIXED_PRIORITY : arbitration mode encodings
//   chan_width(n)                         : width of a channel index for n inputs (min 1)
package arbitrated_multiplexor_pkg;

  localparam int ARB_ROUND_ROBIN    = 0;
  localparam int ARB_FIXED_PRIORITY = 1;

  // A two-input block still needs a 1-bit index, so clamp at 1.
  function automatic int chan_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arbitrated_multiplexor_arbiter.sv
// round_robin_arbiter: purely combinational request arbiter.
//   req           : request vector, bit i = channel i requesting
//   ptr           : round-robin start index (ignored in fixed-priority mode)
//   grant         : one-hot grant, all zero when nothing requests
//   winner        : binary index of the granted channel (0 when idle)
//   any_request   : OR of req
module round_robin_arbiter
  import arbitrated_multiplexor_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int ARB_MODE   = ARB_ROUND_ROBIN,
  localparam int CHANNEL_WIDTH = chan_width(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0]    req,
  input  logic [CHANNEL_WIDTH-1:0] ptr,
  output logic [NUM_INPUTS-1:0]    grant,
  output logic [CHANNEL_WIDTH-1:0] winner,
  output logic                     any_request
);

  // Fixed priority is just a round-robin scan that always starts at 0.
  logic [CHANNEL_WIDTH-1:0] start;
  assign start       = (ARB_MODE == ARB_FIXED_PRIORITY) ? '0 : ptr;
  assign any_request = |req;

  // Scan upward from start; the wrap is a subtract rather than a modulo
  // bit-mask so non-power-of-two channel counts wrap at NUM_INPUTS.
  always_comb begin
    int  idx;
    logic found;
    idx    = 0;
    found  = 1'b0;
    grant  = '0;
    winner = '0;
    for (int off = 0; off < NUM_INPUTS; off++) begin
      idx = int'(start) + off;
      if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        winner     = CHANNEL_WIDTH'(idx);
      end
    end
  end

endmodule

// File: rtl/arbitrated_multiplexor.sv
// arbitrated_multiplexor: N-input registered mux with valid/ready handshakes.
//   clock, reset          : single clock, synchronous active-high reset
//   in_valid / in_ready   : per-channel handshake (one in_ready at most)
//   in_data               : channel i at [i*BIT_WIDTH +: BIT_WIDTH]
//   out_valid / out_ready : output register handshake
//   out_data, out_channel : registered word and the channel that supplied it
module arbitrated_multiplexor
  import arbitrated_multiplexor_pkg::*;
#(
  parameter int BIT_WIDTH  = 32,
  parameter int NUM_INPUTS = 4,
  parameter int ARB_MODE   = ARB_ROUND_ROBIN,
  localparam int CHANNEL_WIDTH = chan_width(NUM_INPUTS)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_INPUTS-1:0]           in_valid,
  input  logic [NUM_INPUTS*BIT_WIDTH-1:0] in_data,
  output logic [NUM_INPUTS-1:0]           in_ready,
  output logic                            out_valid,
  output logic [BIT_WIDTH-1:0]            out_data,
  output logic [CHANNEL_WIDTH-1:0]        out_channel,
  input  logic                            out_ready
);

  logic                     load;
  logic                     any_req;
  logic [NUM_INPUTS-1:0]    grant;
  logic [CHANNEL_WIDTH-1:0] winner;
  logic [CHANNEL_WIDTH-1:0] rr_pointer;
  logic [CHANNEL_WIDTH-1:0] ptr_next;
  logic [BIT_WIDTH-1:0]     sel_data;

  // Register is empty or being drained this cycle, so it can take a word.
  assign load = !out_valid | out_ready;

  round_robin_arbiter #(
    .NUM_INPUTS (NUM_INPUTS),
    .ARB_MODE   (ARB_MODE)
  ) u_arb (
    .req         (in_valid),
    .ptr         (rr_pointer),
    .grant       (grant),
    .winner      (winner),
    .any_request (any_req)
  );

  assign in_ready = (load && any_req && !reset) ? grant : '0;

  // AND-OR select: one-hot grant masks every lane, then OR them together.
  logic [NUM_INPUTS-1:0][BIT_WIDTH-1:0] masked;
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
    assign masked[i] = in_data[i*BIT_WIDTH +: BIT_WIDTH] & {BIT_WIDTH{grant[i]}};
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_INPUTS; i++) sel_data = sel_data | masked[i];
  end

  assign ptr_next = (winner == CHANNEL_WIDTH'(NUM_INPUTS-1)) ? '0
                                                             : winner + CHANNEL_WIDTH'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_channel <= '0;
      rr_pointer  <= '0;
    end else if (load) begin
      if (any_req) begin
        out_valid   <= 1'b1;
        out_data    <= sel_data;
        out_channel <= winner;
        if (ARB_MODE == ARB_ROUND_ROBIN) rr_pointer <= ptr_next;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arbitrated_multiplexor.sv
// Directed bench: round-robin 4x32, fixed-priority 4x32 and round-robin 3x8.
module tb_arbitrated_multiplexor;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // A: round-robin, 4 x 32
  logic [3:0]   a_valid, a_ready;
  logic [127:0] a_data;
  logic         a_ovalid, a_ordy;
  logic [31:0]  a_odata;
  logic [1:0]   a_ochan;
  // B: fixed priority, 4 x 32
  logic [3:0]   b_valid, b_ready;
  logic [127:0] b_data;
  logic         b_ovalid, b_ordy;
  logic [31:0]  b_odata;
  logic [1:0]   b_ochan;
  // C: round-robin, 3 x 8
  logic [2:0]   c_valid, c_ready;
  logic [23:0]  c_data;
  logic         c_ovalid, c_ordy;
  logic [7:0]   c_odata;
  logic [1:0]   c_ochan;

  arbitrated_multiplexor #(.BIT_WIDTH(32), .NUM_INPUTS(4), .ARB_MODE(0)) dut_a (
    .clock(clock), .reset(reset), .in_valid(a_valid), .in_data(a_data),
    .in_ready(a_ready), .out_valid(a_ovalid), .out_data(a_odata),
    .out_channel(a_ochan), .out_ready(a_ordy));

  arbitrated_multiplexor #(.BIT_WIDTH(32), .NUM_INPUTS(4), .ARB_MODE(1)) dut_b (
    .clock(clock), .reset(reset), .in_valid(b_valid), .in_data(b_data),
    .in_ready(b_ready), .out_valid(b_ovalid), .out_data(b_odata),
    .out_channel(b_ochan), .out_ready(b_ordy));

  arbitrated_multiplexor #(.BIT_WIDTH(8), .NUM_INPUTS(3), .ARB_MODE(0)) dut_c (
    .clock(clock), .reset(reset), .in_valid(c_valid), .in_data(c_data),
    .in_ready(c_ready), .out_valid(c_ovalid), .out_data(c_odata),
    .out_channel(c_ochan), .out_ready(c_ordy));

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled there too.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic v, input logic [31:0] d, input logic [1:0] c);
    chk({tag, "_valid"}, 64'(a_ovalid), 64'(v));
    chk({tag, "_data"},  64'(a_odata),  64'(d));
    chk({tag, "_chan"},  64'(a_ochan),  64'(c));
  endtask

  int c_cnt [3];
  int c_seq [6];

  initial begin
    reset = 1'b1;
    a_valid = '0; b_valid = '0; c_valid = '0;
    a_ordy = 1'b0; b_ordy = 1'b0; c_ordy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_data[i*32 +: 32] = 32'hA0 + 32'(i);
      b_data[i*32 +: 32] = 32'hB0 + 32'(i);
    end
    for (int i = 0; i < 3; i++) c_data[i*8 +: 8] = 8'h10 + 8'(i);
    c_seq = '{0, 1, 2, 0, 1, 2};
    c_cnt = '{0, 0, 0};

    // ---- reset state
    tick();
    a_valid = 4'hF;
    #1 chk("rst_in_ready", 64'(a_ready), 64'h0);
    tick();
    chk_a("rst", 1'b0, 32'h0, 2'd0);
    chk("rst_ptr", 64'(dut_a.rr_pointer), 64'd0);

    // ---- round-robin streaming, first grant to channel 0
    reset = 1'b0; a_ordy = 1'b1;
    #1 chk("first_ready", 64'(a_ready), 64'b0001);
    chk("first_no_valid", 64'(a_ovalid), 64'd0);
    tick(); chk_a("rr0", 1'b1, 32'hA0, 2'd0);
    #1 chk("rr0_ready", 64'(a_ready), 64'b0010);
    tick(); chk_a("rr1", 1'b1, 32'hA1, 2'd1);

    // ---- backpressure holding 0xA1
    a_ordy = 1'b0;
    #1 chk("stall_ready0", 64'(a_ready), 64'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_a("stall", 1'b1, 32'hA1, 2'd1);
      chk("stall_ready", 64'(a_ready), 64'h0);
    end
    a_ordy = 1'b1;
    #1 chk("release_ready", 64'(a_ready), 64'b0100);
    tick(); chk_a("rr2", 1'b1, 32'hA2, 2'd2);
    tick(); chk_a("rr3", 1'b1, 32'hA3, 2'd3);
    tick(); chk_a("rr4", 1'b1, 32'hA0, 2'd0);
    tick(); chk_a("rr5", 1'b1, 32'hA1, 2'd1);
    chk("rr5_ptr", 64'(dut_a.rr_pointer), 64'd2);

    // ---- wrap: grant 2 (ptr 3), then only channel 0
    tick(); chk_a("wrap2", 1'b1, 32'hA2, 2'd2);
    chk("wrap2_ptr", 64'(dut_a.rr_pointer), 64'd3);
    a_valid = 4'b0001;
    #1 chk("wrap_ready", 64'(a_ready), 64'b0001);
    tick(); chk_a("wrap0", 1'b1, 32'hA0, 2'd0);
    chk("wrap0_ptr", 64'(dut_a.rr_pointer), 64'd1);
    a_valid = 4'b0011;
    #1 chk("pair_ready", 64'(a_ready), 64'b0010);
    tick(); chk_a("pair1", 1'b1, 32'hA1, 2'd1);

    // ---- drain without refill: data/channel/pointer hold
    a_valid = 4'b0000;
    #1 chk("drain_ready", 64'(a_ready), 64'h0);
    tick(); chk_a("drain", 1'b0, 32'hA1, 2'd1);
    chk("drain_ptr", 64'(dut_a.rr_pointer), 64'd2);
    a_valid = 4'b0011;
    #1 chk("pair0_ready", 64'(a_ready), 64'b0001);
    tick(); chk_a("pair0", 1'b1, 32'hA0, 2'd0);

    // ---- reset mid-transfer with a pending word
    a_valid = 4'hF; a_ordy = 1'b0; reset = 1'b1;
    #1 chk("midrst_ready", 64'(a_ready), 64'h0);
    tick(); chk_a("midrst", 1'b0, 32'h0, 2'd0);
    chk("midrst_ptr", 64'(dut_a.rr_pointer), 64'd0);
    reset = 1'b0; a_ordy = 1'b1;
    #1 chk("postrst_ready", 64'(a_ready), 64'b0001);
    tick(); chk_a("postrst", 1'b1, 32'hA0, 2'd0);
    a_valid = '0;

    // ---- fixed priority: channels 1 and 3 always valid
    b_valid = 4'b1010; b_ordy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("fp_ready", 64'(b_ready), 64'b0010);
      tick();
      chk("fp_chan", 64'(b_ochan), 64'd1);
      chk("fp_data", 64'(b_odata), 64'hB1);
    end
    chk("fp_ptr", 64'(dut_b.rr_pointer), 64'd0);

    // ---- non-power-of-two, 3 channels
    c_valid = 3'b111; c_ordy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1 chk("np2_ready", 64'(c_ready), 64'(3'b001 << c_seq[i]));
      tick();
      chk("np2_chan", 64'(c_ochan), 64'(c_seq[i]));
      chk("np2_data", 64'(c_odata), 64'(8'h10 + 8'(c_seq[i])));
      if (c_ochan < 2'd3) c_cnt[c_ochan] = c_cnt[c_ochan] + 1;
    end
    for (int i = 0; i < 3; i++) chk("np2_fair", 64'(c_cnt[i]), 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/arbitrated_multiplexor.md
Name: arbitrated_multiplexor

Overview:
N-input, BIT_WIDTH-wide registered multiplexor with per-channel valid/ready handshakes. An internal arbiter, round-robin or fixed-priority, picks one requesting channel per transfer. It drives one registered output stream plus the index of the winning channel. It is the sequential successor to the 2x1/4x1 combinational muxes and merges several producer streams onto one consumer, e.g. shared memory or result-bus ports.

Parameters:
- BIT_WIDTH, 32, data width per channel.
- NUM_INPUTS, 4, number of input channels; must be >= 2; need not be a power of two.
- ARB_MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins).
- CHANNEL_WIDTH, derived = max(1, clog2(NUM_INPUTS)), width of the channel index.

Ports:
- clock, input, 1, single clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-high.
- in_valid, input, NUM_INPUTS, bit i = channel i has data.
- in_data, input, NUM_INPUTS*BIT_WIDTH, channel i occupies [i*BIT_WIDTH +: BIT_WIDTH].
- in_ready, output, NUM_INPUTS, bit i = channel i transfer accepted this cycle.
- out_valid, output, 1, output register holds data.
- out_data, output, BIT_WIDTH, registered selected data.
- out_channel, output, CHANNEL_WIDTH, index of the channel that supplied out_data.
- out_ready, input, 1, consumer accepts out_data this cycle.

Behaviour:
- Reset: while reset is high, in_ready = 0. On the clock edge with reset high: out_valid <= 0, out_data <= 0, out_channel <= 0, rr_pointer <= 0.
- Reset mid-operation: any pending output word is discarded; no input is accepted during the reset cycle.
- load = !out_valid | out_ready. This is the output register's empty-or-draining condition and allows full throughput.
- Winner selection, combinational, among channels with in_valid set:
  - ARB_MODE 0: the first set bit scanning upward from rr_pointer, wrapping NUM_INPUTS-1 -> 0.
  - ARB_MODE 1: the lowest set index; rr_pointer is unused and held at 0.
- Handshake: in_ready[w] = load & any(in_valid) & (w == winner). At most one in_ready bit is high in any cycle. in_ready never depends on a channel's own in_valid except through arbitration, and it is 0 for non-winners.
- Transfer (load and any in_valid):
  - out_data <= in_data[winner], out_channel <= winner, out_valid <= 1.
  - round-robin: rr_pointer <= (winner == NUM_INPUTS-1) ? 0 : winner+1. The wrap must be correct for non-power-of-two NUM_INPUTS.
- Drain without refill (load, no in_valid): out_valid <= 0. out_data and out_channel hold their last values. rr_pointer holds.
- Stall (out_valid & !out_ready): out_valid, out_data, out_channel and rr_pointer all hold; all in_ready = 0.
- Latency: an input accepted at edge k appears on out_data after edge k, i.e. 1 cycle. Sustained throughput is 1 word/cycle when out_ready = 1.
- Simultaneous events: the output is consumed and the register refilled in the same cycle when out_valid & out_ready & any(in_valid).
- Fairness, round-robin: with all NUM_INPUTS channels continuously valid, each channel is granted exactly once per NUM_INPUTS consecutive transfers.
- Input contract: a producer must keep in_valid and in_data stable until its in_ready is seen. The block does not check this.

Decomposition:
- Shared package: constants ARB_ROUND_ROBIN = 0 and ARB_FIXED_PRIORITY = 1, plus a clog2-based CHANNEL_WIDTH helper function.
- One sub-module: round_robin_arbiter (parameters NUM_INPUTS, ARB_MODE). Inputs: request vector, pointer. Outputs: one-hot grant, binary winner index, any_request. It is purely combinational.
- Top level holds the output register, rr_pointer, load logic and data select. The data select is an AND-OR of the one-hot grant with in_data, not a chain of 2x1 instances.

Test Plan:
- Round-robin, NUM_INPUTS=4, all valid, in_data[i]=0xA0+i, out_ready=1, after reset:
  - out_channel sequence is 0,1,2,3,0,… one per cycle, with out_data 0xA0,0xA1,0xA2,0xA3,…;
  - first out_valid appears 1 cycle after the first in_ready.
- Backpressure:
  - after out_valid=1 with out_data=0xA1, hold out_ready=0 for 4 cycles -> out_data stays 0xA1, in_ready=0000 throughout;
  - release out_ready -> out_channel=2 next.
- Fixed priority, ARB_MODE=1: channels 1 and 3 valid continuously, out_ready=1 -> out_channel=1 every cycle and in_ready=0010 every cycle.
- Wrap, round-robin: grant channel 2 (rr_pointer becomes 3), then only channel 0 valid -> channel 0 granted and rr_pointer=1. Then channels 0 and 1 valid -> 1 granted before 0.
- Reset mid-transfer: out_valid=1, out_ready=0, assert reset for 1 cycle with all in_valid=1 -> in_ready=0 during reset. Next cycle: out_valid=0, out_data=0, out_channel=0, rr_pointer=0. The first grant after reset goes to channel 0.
- Non-power-of-two, NUM_INPUTS=3, BIT_WIDTH=8, all valid -> out_channel sequence is 0,1,2,0,1 (2-bit index); out_channel never reaches 3. Each channel gets exactly 1 grant per 3 transfers.
